dd_tx_sched: RTL
================

Name: dd_tx_sched

Overview:
- Sits directly downstream of the data-delivery engine and consumes its two per-cycle event outputs:
  - next-sequence descriptors (fid, seq, tx_id);
  - timeout events (flag, fid).
- Buffers each stream in its own FIFO.
- Arbitrates between the two streams onto a single ready/valid descriptor port feeding the packet generator.
- Counts events dropped on overflow.

Parameters:
- FLOW_ID_W, 10, flow id width; all-ones value is FLOW_ID_NONE.
- FLOW_SEQ_NUM_W, 32, sequence number width.
- TX_CNT_W, 2, transmission-id width.
- FLAG_W, 1, timeout flag width.
- SEQ_DEPTH, 16, sequence FIFO entries (power of two, ≥2).
- TO_DEPTH, 8, timeout FIFO entries (power of two, ≥2).
- TO_BURST, 4, maximum consecutive timeout grants while the sequence FIFO is non-empty.
- DROP_CNT_W, 16, width of each drop counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- next_seq_fid_in  in  FLOW_ID_W  descriptor fid; FLOW_ID_NONE = no descriptor this cycle.
- next_seq_in  in  FLOW_SEQ_NUM_W  descriptor sequence number.
- next_seq_tx_id_in  in  TX_CNT_W  descriptor transmission id.
- timeout_val_in  in  FLAG_W  non-zero = timeout event this cycle.
- timeout_fid_in  in  FLOW_ID_W  timed-out flow.
- out_valid  out  1  descriptor available.
- out_ready  in  1  consumer accepts descriptor.
- out_fid  out  FLOW_ID_W  granted fid.
- out_seq  out  FLOW_SEQ_NUM_W  sequence number; 0 for timeout entries.
- out_tx_id  out  TX_CNT_W  tx id; 0 for timeout entries.
- out_is_timeout  out  1  1 = entry came from timeout FIFO.
- seq_drop_cnt  out  DROP_CNT_W  saturating count of dropped descriptors.
- to_drop_cnt  out  DROP_CNT_W  saturating count of dropped timeouts.

Behaviour:
- Reset (rst=1 sampled at an edge):
  - both FIFOs emptied;
  - out_valid=0, out_fid=FLOW_ID_NONE, out_seq=0, out_tx_id=0, out_is_timeout=0;
  - both drop counters=0; burst counter=0.
  - Reset mid-operation discards all queued and held entries with no output.
- Input acceptance, every cycle, with no back-pressure to the upstream engine:
  - descriptor valid iff next_seq_fid_in != FLOW_ID_NONE;
  - timeout valid iff timeout_val_in != 0 and timeout_fid_in != FLOW_ID_NONE.
  - Both may occur in the same cycle; each goes to its own FIFO. There is no de-duplication.
- Overflow:
  - A write to a full FIFO is dropped and that FIFO's drop counter increments, saturating at all-ones.
  - A write in the same cycle as a pop from a full FIFO is accepted (pop frees the slot first).
- Output register:
  - Loads on an edge when (!out_valid || out_ready) and at least one FIFO is non-empty; the chosen FIFO pops in that same cycle.
  - Otherwise out_valid clears if out_ready was high, and holds otherwise.
  - While out_valid && !out_ready, all out_* fields stay stable.
- Latency: an event sampled at edge N appears with out_valid=1 after edge N+1 (2 cycles), given an idle output and empty FIFOs.
- Arbitration at each load:
  - timeout FIFO wins if non-empty, unless burst_cnt == TO_BURST and the sequence FIFO is non-empty, in which case the sequence FIFO wins.
  - burst_cnt increments on a timeout grant and clears on a sequence grant.
  - burst_cnt also clears whenever the timeout FIFO is empty at a load.
- Pointer arithmetic:
  - read/write pointers are log2(DEPTH)+1 bits with natural wrap;
  - full = MSBs differ and LSBs equal; empty = pointers equal.

Decomposition:
- Shared constants header: FLOW_ID_W, FLOW_SEQ_NUM_W, TX_CNT_W, FLAG_W, FLOW_ID_NONE, plus the output descriptor field layout (fid|seq|tx_id|is_timeout), so the packet generator uses the same layout.
- One sub-module, dd_sync_fifo: parameterised width/depth, 1 write, 1 show-ahead read, full/empty flags.
  - Instanced twice: sequence width = FLOW_ID_W+FLOW_SEQ_NUM_W+TX_CNT_W; timeout width = FLOW_ID_W.

Test Plan:
- Reset then single descriptor (fid=5, seq=100, tx=1) at cycle 3, out_ready=1 -> out_valid=1 after edge 4 with fid=5, seq=100, tx_id=1, is_timeout=0; out_valid=0 the following cycle.
- Same-cycle descriptor (fid=7, seq=9) and timeout (fid=3), out_ready=1 -> timeout fid=3 granted first, then fid=7 seq=9 on the next cycle.
- out_ready=0 for 20 cycles while 20 descriptors arrive (SEQ_DEPTH=16) -> held entry stable; seq_drop_cnt=3 (1 held + 16 queued); then ready=1 -> 17 descriptors drain in order.
- 6 timeouts and 2 descriptors queued, out_ready=1 -> grant order T,T,T,T,S,T,T,S (TO_BURST=4).
- Invalid inputs (fid=FLOW_ID_NONE, timeout_val=0) for 50 cycles -> out_valid stays 0 and both counters stay 0; rst=1 with 5 entries queued -> out_valid=0 the next cycle and no entries emerge afterward.

Source files
------------

// File: rtl/dd_tx_sched_pkg.sv
// Shared constants and descriptor layout for the data-delivery TX scheduler.
// The packet generator imports the same layout so both sides agree on field order.
package dd_tx_sched_pkg;
  localparam int FLOW_ID_W      = 10;
  localparam int FLOW_SEQ_NUM_W = 32;
  localparam int TX_CNT_W       = 2;
  localparam int FLAG_W         = 1;

  localparam logic [FLOW_ID_W-1:0] FLOW_ID_NONE = '1;

  typedef struct packed {
    logic [FLOW_ID_W-1:0]      fid;
    logic [FLOW_SEQ_NUM_W-1:0] seq;
    logic [TX_CNT_W-1:0]       tx_id;
  } seq_ent_t;

  // Output descriptor layout: fid | seq | tx_id | is_timeout
  typedef struct packed {
    logic [FLOW_ID_W-1:0]      fid;
    logic [FLOW_SEQ_NUM_W-1:0] seq;
    logic [TX_CNT_W-1:0]       tx_id;
    logic                      is_timeout;
  } tx_desc_t;

  localparam tx_desc_t DESC_IDLE = '{FLOW_ID_NONE, '0, '0, 1'b0};

  function automatic tx_desc_t seq_to_desc(input seq_ent_t e);
    return '{e.fid, e.seq, e.tx_id, 1'b0};
  endfunction

  function automatic tx_desc_t to_to_desc(input logic [FLOW_ID_W-1:0] fid);
    return '{fid, '0, '0, 1'b1};
  endfunction
endpackage

// File: rtl/dd_tx_sched_if.sv
// Event inputs from the delivery engine and the descriptor port to the packet generator.
interface dd_tx_sched_if import dd_tx_sched_pkg::*; #(
  parameter int DROP_CNT_W = 16
);
  logic [FLOW_ID_W-1:0]      next_seq_fid_in;
  logic [FLOW_SEQ_NUM_W-1:0] next_seq_in;
  logic [TX_CNT_W-1:0]       next_seq_tx_id_in;
  logic [FLAG_W-1:0]         timeout_val_in;
  logic [FLOW_ID_W-1:0]      timeout_fid_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [FLOW_ID_W-1:0]      out_fid;
  logic [FLOW_SEQ_NUM_W-1:0] out_seq;
  logic [TX_CNT_W-1:0]       out_tx_id;
  logic                      out_is_timeout;
  logic [DROP_CNT_W-1:0]     seq_drop_cnt;
  logic [DROP_CNT_W-1:0]     to_drop_cnt;

  modport slave (
    input  next_seq_fid_in, next_seq_in, next_seq_tx_id_in, timeout_val_in, timeout_fid_in,
           out_ready,
    output out_valid, out_fid, out_seq, out_tx_id, out_is_timeout, seq_drop_cnt, to_drop_cnt
  );

  modport master (
    output next_seq_fid_in, next_seq_in, next_seq_tx_id_in, timeout_val_in, timeout_fid_in,
           out_ready,
    input  out_valid, out_fid, out_seq, out_tx_id, out_is_timeout, seq_drop_cnt, to_drop_cnt
  );
endinterface

// File: rtl/dd_sync_fifo.sv
// Single-clock FIFO with show-ahead read; pointers carry one extra wrap bit.
module dd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Write to a full FIFO is only issued alongside a pop, so the slot being read is reused.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/dd_tx_sched.sv
// Buffers next-sequence and timeout events and arbitrates them onto one descriptor port,
// favouring timeouts but capping consecutive timeout grants while descriptors wait.
module dd_tx_sched import dd_tx_sched_pkg::*; #(
  parameter int SEQ_DEPTH  = 16,
  parameter int TO_DEPTH   = 8,
  parameter int TO_BURST   = 4,
  parameter int DROP_CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  dd_tx_sched_if.slave bus
);
  localparam int BW = $clog2(TO_BURST + 1);

  seq_ent_t              seq_wdata, seq_rdata;
  logic [FLOW_ID_W-1:0]  to_rdata;
  logic                  seq_full, seq_empty, to_full, to_empty;
  logic                  seq_in_vld, to_in_vld, seq_push, to_push, seq_pop, to_pop;
  logic                  load, pick_to, out_vld;
  logic [BW-1:0]         burst_cnt;
  logic [DROP_CNT_W-1:0] seq_drop, to_drop;
  tx_desc_t              out_q, grant;

  assign seq_in_vld = (bus.next_seq_fid_in != FLOW_ID_NONE);
  assign to_in_vld  = (bus.timeout_val_in != '0) && (bus.timeout_fid_in != FLOW_ID_NONE);
  assign seq_wdata  = '{bus.next_seq_fid_in, bus.next_seq_in, bus.next_seq_tx_id_in};

  assign load    = (!out_vld || bus.out_ready) && !(seq_empty && to_empty);
  assign pick_to = !to_empty && !((burst_cnt == BW'(TO_BURST)) && !seq_empty);
  assign to_pop  = load && pick_to;
  assign seq_pop = load && !pick_to;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign seq_push = seq_in_vld && (!seq_full || seq_pop);
  assign to_push  = to_in_vld && (!to_full || to_pop);

  assign grant = pick_to ? to_to_desc(to_rdata) : seq_to_desc(seq_rdata);

  dd_sync_fifo #(.WIDTH($bits(seq_ent_t)), .DEPTH(SEQ_DEPTH)) u_seq_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (seq_push),
    .wr_data (seq_wdata),
    .rd_en   (seq_pop),
    .rd_data (seq_rdata),
    .full    (seq_full),
    .empty   (seq_empty)
  );

  dd_sync_fifo #(.WIDTH(FLOW_ID_W), .DEPTH(TO_DEPTH)) u_to_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (to_push),
    .wr_data (bus.timeout_fid_in),
    .rd_en   (to_pop),
    .rd_data (to_rdata),
    .full    (to_full),
    .empty   (to_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_q     <= DESC_IDLE;
      burst_cnt <= '0;
      seq_drop  <= '0;
      to_drop   <= '0;
    end else begin
      if (load) begin
        out_vld <= 1'b1;
        out_q   <= grant;
      end else if (bus.out_ready) begin
        out_vld <= 1'b0;
      end
      // Burst count saturates so a long timeout-only stretch yields to the next descriptor.
      if (load) begin
        if (!pick_to)                          burst_cnt <= '0;
        else if (burst_cnt != BW'(TO_BURST))   burst_cnt <= burst_cnt + 1'b1;
      end
      if (seq_in_vld && !seq_push && seq_drop != '1) seq_drop <= seq_drop + 1'b1;
      if (to_in_vld && !to_push && to_drop != '1)    to_drop  <= to_drop + 1'b1;
    end
  end

  assign bus.out_valid      = out_vld;
  assign bus.out_fid        = out_q.fid;
  assign bus.out_seq        = out_q.seq;
  assign bus.out_tx_id      = out_q.tx_id;
  assign bus.out_is_timeout = out_q.is_timeout;
  assign bus.seq_drop_cnt   = seq_drop;
  assign bus.to_drop_cnt    = to_drop;
endmodule
